fp_square_seq: RTL and testbench
================================

Name: fp_square_seq

Overview:
- Iterative IEEE754 single-precision squaring unit: takes one binary32 operand, returns x*x as binary32.
- Computes the 24x24 mantissa product by shift-and-add, one partial product per cycle, into a 48-bit accumulator.
- Adds the exponent, then normalizes and rounds in one final cycle.
- Sits between the operand-select front end and the calculator result mux; valid/ready on both sides.

Parameters:
- BIAS, 127, exponent bias.
- MANT_W, 24, significand width including the hidden bit; the accumulator is 2*MANT_W bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand.
- in_a  input  32  binary32 operand.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_res  output  32  binary32 square.
- out_ovf  output  1  result overflowed to +inf.
- out_unf  output  1  result underflowed or was flushed to +0.
- out_nv  output  1  input was NaN.

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, in_ready=1, out_valid=0, out_res=0, all flags 0, accumulator and counter cleared.
- Reset deasserted mid-operation: the in-flight operation is discarded and no result is produced.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_a and classify it, then go to MUL with counter=0.
  - MUL: one iteration per cycle. If multiplier bit[counter]=1, acc += M<<counter (48-bit add, carry-out discarded). Stay for exactly 24 cycles, then go to NORM.
  - NORM: register the normalized/rounded result and flags, then go to DONE.
  - DONE: out_valid=1 with out_res/flags held stable. On out_ready, go to IDLE; in_ready rises the next cycle.
- in_ready=0 in MUL, NORM and DONE; there is no overlap of operations.
- Latency: out_valid is high 26 cycles after the accept edge. This is fixed, including special cases.
- Significand: M = {1, frac}.
  - P = M*M, which lies in [2^46, 2^48).
  - n = P[47].
  - If n=1: mant = P[46:24], guard = P[23], sticky = |P[22:0].
  - If n=0: mant = P[45:23], guard = P[22], sticky = |P[21:0].
- Exponent: computed as a 10-bit signed value, e2 = 2*E - BIAS + n.
- Result sign is always 0.
- Special cases (priority top-down, decided at accept, still full latency):
  - E=255, frac!=0 (NaN): out_res=0x7FC00000, nv=1.
  - E=255, frac=0 (inf): 0x7F800000, no flags.
  - E=0 (zero or denormal; denormals are flushed): 0x00000000. unf=1 only if frac!=0.
- Overflow: e2>=255 after rounding gives 0x7F800000, ovf=1.
- Underflow: e2<=0 gives 0x00000000, unf=1. There are no subnormal outputs.
- Rounding carry out of mant: mant becomes 0 and e2 increments by 1; re-check overflow.

Optional Feature:
- FP_SQ_RNE_EN defined: round to nearest even. Round up when guard&(sticky|mant[0]).
- FP_SQ_RNE_EN undefined: truncate (round toward zero); guard and sticky are ignored.
- Latency is identical in both builds.

Decomposition:
- Package fp_square_pkg holds:
  - state enum {IDLE, MUL, NORM, DONE};
  - BIAS, EXP_MAX=255;
  - QNAN=0x7FC00000, PINF=0x7F800000;
  - the 10-bit signed exponent typedef.
- Sub-module fp_square_round: purely combinational normalize/round/exponent-check, taking P and the biased E. It returns result and flags and contains the FP_SQ_RNE_EN logic, so it can be tested standalone.

Test Plan:
- 0x40400000 (3.0) → out_res=0x41100000 (9.0), flags 0, out_valid exactly 26 cycles after accept.
- 0xBFC00000 (-1.5) → 0x40100000 (2.25). 0x80000000 (-0) → 0x00000000, unf=0.
- 0x3FC00001 → 0x40100002 with FP_SQ_RNE_EN, 0x40100001 without.
- 0x60AD78EC (1e20) → 0x7F800000, ovf=1. 0x1C800000 (2^-70) → 0x00000000, unf=1. 0x7FA00000 → 0x7FC00000, nv=1.
- out_ready held low 10 cycles in DONE: out_res stable, in_ready=0, a new in_valid is not accepted. After out_ready, in_ready returns the next cycle and back-to-back operands both complete correctly.
- rst_n pulsed low during MUL cycle 12: outputs return to reset values immediately. The next operand 0x40000000 → 0x40800000 with full latency.

Source files
------------

// File: rtl/fp_square_pkg.sv
// ---------------------------------------------------------------------------
// fp_square_pkg : shared types and constants for the binary32 squaring unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fp_square_pkg;

    localparam int          BIAS    = 127;
    localparam int          EXP_MAX = 255;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] PINF    = 32'h7F80_0000;

    typedef logic signed [9:0] exp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CLS_NORMAL = 3'd0,
        CLS_NAN    = 3'd1,
        CLS_INF    = 3'd2,
        CLS_ZERO   = 3'd3,
        CLS_DENORM = 3'd4
    } cls_e;

    // Operand class, in the priority order the result mux resolves specials
    function automatic cls_e classify(input logic [31:0] a);
        cls_e c;
        if (a[30:23] == 8'hFF) begin
            c = (a[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        end else if (a[30:23] == 8'h00) begin
            c = (a[22:0] != 23'd0) ? CLS_DENORM : CLS_ZERO;
        end else begin
            c = CLS_NORMAL;
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_square_round.sv
// ---------------------------------------------------------------------------
// fp_square_round : normalize, round and range-check a 48-bit significand square
// Rev 1.0 -- define FP_SQ_RNE_EN for round-to-nearest-even, else truncate
// ---------------------------------------------------------------------------
`default_nettype none

module fp_square_round
    import fp_square_pkg::*;
#(
    parameter int BIAS = fp_square_pkg::BIAS
) (
    input  logic [47:0] prod_i,
    input  logic [7:0]  exp_i,
    output logic [31:0] res_o,
    output logic        ovf_o,
    output logic        unf_o
);

`ifdef FP_SQ_RNE_EN
    localparam logic c_rne = 1'b1;
`else
    localparam logic c_rne = 1'b0;
`endif

    logic        w_n;
    logic [22:0] w_mant;
    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [23:0] w_mant_r;
    logic [22:0] w_mant_f;
    exp_t        w_e2;
    exp_t        w_e2_f;

    always_comb begin
        w_n      = prod_i[47];
        w_mant   = w_n ? prod_i[46:24] : prod_i[45:23];
        w_guard  = w_n ? prod_i[23]    : prod_i[22];
        w_sticky = w_n ? (|prod_i[22:0]) : (|prod_i[21:0]);

        w_e2 = exp_t'({2'b00, exp_i}) + exp_t'({2'b00, exp_i})
             - exp_t'(BIAS) + exp_t'({9'd0, w_n});

        // With truncation selected the mask forces round_up low
        w_round_up = c_rne & w_guard & (w_sticky | w_mant[0]);
        w_mant_r   = {1'b0, w_mant} + {23'd0, w_round_up};

        if (w_mant_r[23]) begin
            w_mant_f = 23'd0;
            w_e2_f   = w_e2 + exp_t'(1);
        end else begin
            w_mant_f = w_mant_r[22:0];
            w_e2_f   = w_e2;
        end

        res_o = 32'd0;
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (w_e2_f >= exp_t'(EXP_MAX)) begin
            res_o = PINF;
            ovf_o = 1'b1;
        end else if (w_e2_f <= exp_t'(0)) begin
            unf_o = 1'b1;
        end else begin
            res_o = {1'b0, w_e2_f[7:0], w_mant_f};
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_square_seq.sv
// ---------------------------------------------------------------------------
// fp_square_seq : iterative binary32 squarer, shift-and-add over 24 cycles
// Rev 1.0 -- FP_SQ_RNE_EN selects round-to-nearest-even (see fp_square_round)
// ---------------------------------------------------------------------------
`default_nettype none

module fp_square_seq
    import fp_square_pkg::*;
#(
    parameter int BIAS   = 127,
    parameter int MANT_W = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_nv
);

    localparam int CNT_W = $clog2(MANT_W);
    localparam int ACC_W = 2 * MANT_W;

    state_e              state_q, state_d;
    cls_e                cls_q, cls_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [MANT_W-1:0]   m_q, m_d;
    logic [7:0]          e_q, e_d;
    logic [31:0]         res_q, res_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                nv_q, nv_d;

    logic [31:0]         w_rnd_res;
    logic                w_rnd_ovf;
    logic                w_rnd_unf;

    fp_square_round #(
        .BIAS (BIAS)
    ) u_round (
        .prod_i (acc_q),
        .exp_i  (e_q),
        .res_o  (w_rnd_res),
        .ovf_o  (w_rnd_ovf),
        .unf_o  (w_rnd_unf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cls_q   <= CLS_ZERO;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            e_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            nv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            e_q     <= e_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            nv_q    <= nv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        e_d     = e_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        nv_d    = nv_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = {1'b1, in_a[MANT_W-2:0]};
                    e_d     = in_a[30:23];
                    cls_d   = classify(in_a);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MUL;
                end
            end
            MUL: begin
                // Multiplicand and multiplier are the same significand
                if (m_q[cnt_q]) begin
                    acc_d = acc_q + ({{MANT_W{1'b0}}, m_q} << cnt_q);
                end
                if (cnt_q == CNT_W'(MANT_W - 1)) begin
                    state_d = NORM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            NORM: begin
                res_d = w_rnd_res;
                ovf_d = w_rnd_ovf;
                unf_d = w_rnd_unf;
                nv_d  = 1'b0;
                case (cls_q)
                    CLS_NAN: begin
                        res_d = QNAN;
                        ovf_d = 1'b0;
                        unf_d = 1'b0;
                        nv_d  = 1'b1;
                    end
                    CLS_INF: begin
                        res_d = PINF;
                        ovf_d = 1'b0;
                        unf_d = 1'b0;
                    end
                    CLS_ZERO: begin
                        res_d = 32'd0;
                        ovf_d = 1'b0;
                        unf_d = 1'b0;
                    end
                    CLS_DENORM: begin
                        res_d = 32'd0;
                        ovf_d = 1'b0;
                        unf_d = 1'b1;
                    end
                    default: ;
                endcase
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_res   = res_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;
    assign out_nv    = nv_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_square_seq.sv
// ---------------------------------------------------------------------------
// tb_fp_square_seq : directed self-checking bench for fp_square_seq
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fp_square_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_res;
    logic        out_ovf;
    logic        out_unf;
    logic        out_nv;

    int n_tests = 0;
    int n_fail  = 0;

    fp_square_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .out_nv    (out_nv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Latency counts rising edges with the accept edge as the first one
    task automatic wait_result(input string tag, input logic [31:0] er,
                               input logic eo, input logic eu, input logic en);
        int cyc;
        cyc = 1;
        while (!out_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, 32'd26);
        check({tag, "_res"}, out_res, er);
        check({tag, "_flags"}, {29'd0, out_ovf, out_unf, out_nv}, {29'd0, eo, eu, en});
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after_release", {31'd0, in_ready}, 32'd1);
        check("out_valid_after_release", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] exp_rnd;

        #12;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_res", out_res, 32'd0);
        check("reset_flags", {29'd0, out_ovf, out_unf, out_nv}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 3.0 squared, then stall the consumer for 10 cycles
        start_op(32'h4040_0000);
        wait_result("sq_3p0", 32'h4110_0000, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_a     = 32'h4000_0000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("stall_res", out_res, 32'h4110_0000);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        release_result();

        // back-to-back operands
        start_op(32'hBFC0_0000);
        wait_result("sq_m1p5", 32'h4010_0000, 1'b0, 1'b0, 1'b0);
        release_result();
        start_op(32'h8000_0000);
        wait_result("sq_negzero", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        release_result();

`ifdef FP_SQ_RNE_EN
        exp_rnd = 32'h4010_0002;
`else
        exp_rnd = 32'h4010_0001;
`endif
        start_op(32'h3FC0_0001);
        wait_result("sq_round", exp_rnd, 1'b0, 1'b0, 1'b0);
        release_result();

        start_op(32'h60AD_78EC);
        wait_result("sq_ovf", 32'h7F80_0000, 1'b1, 1'b0, 1'b0);
        release_result();
        start_op(32'h1C80_0000);
        wait_result("sq_unf", 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        release_result();
        start_op(32'h7FA0_0000);
        wait_result("sq_nan", 32'h7FC0_0000, 1'b0, 1'b0, 1'b1);
        release_result();
        start_op(32'hFF80_0000);
        wait_result("sq_inf", 32'h7F80_0000, 1'b0, 1'b0, 1'b0);
        release_result();
        start_op(32'h0000_0001);
        wait_result("sq_denorm", 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        release_result();

        // asynchronous reset during MUL iteration 12
        start_op(32'h4040_0000);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_out_res", out_res, 32'd0);
        check("midrst_flags", {29'd0, out_ovf, out_unf, out_nv}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("midrst_no_result", {31'd0, out_valid}, 32'd0);

        start_op(32'h4000_0000);
        wait_result("sq_2p0", 32'h4080_0000, 1'b0, 1'b0, 1'b0);
        release_result();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
